// File: rtl/frequency_meter_pkg.sv
// rtl/frequency_meter_pkg.sv - shared defaults, FSM encoding and saturating-add helper for frequency_meter
package frequency_meter_pkg;

  localparam int unsigned DEF_GATE_CYCLES = 50_000_000;
  localparam int unsigned DEF_GATE_W      = 26;
  localparam int unsigned DEF_COUNT_W     = 26;

  // Working width of the edge accumulator; COUNT_W must not exceed it.
  localparam int unsigned ACC_W = 32;

  typedef enum logic {
    ST_SETTLE  = 1'b0,
    ST_MEASURE = 1'b1
  } meter_state_e;

  // Adds inc to val, clamping at max_val. Bit ACC_W flags an increment
  // that was attempted while already at max_val.
  function automatic logic [ACC_W:0] sat_inc(input logic [ACC_W-1:0] val,
                                             input logic             inc,
                                             input logic [ACC_W-1:0] max_val);
    logic [ACC_W:0] res;
    res = {1'b0, val};
    if (inc) begin
      if (val == max_val) begin
        res[ACC_W] = 1'b1;
      end else begin
        res[ACC_W-1:0] = val + {{(ACC_W-1){1'b0}}, 1'b1};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/frequency_meter_sync_edge_detect.sv
// rtl/frequency_meter_sync_edge_detect.sv - 2-flop synchronizer with registered rising-edge pulse
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_pulse
);

  logic       meta_q, meta_d;
  logic       sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       edge_q, edge_d;
  logic [1:0] fill_q, fill_d;

  // Pulse is suppressed until prev_q holds a real sample, so a level that is
  // already high at reset release is not mistaken for a rising edge.
  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
    fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    edge_d = (fill_q == 2'd3) && sync_q && !prev_q;
  end

  // Synchronizer, history and edge flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
      fill_q <= 2'd0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      edge_q <= edge_d;
      fill_q <= fill_d;
    end
  end

  assign edge_pulse = edge_q;

endmodule

// File: rtl/frequency_meter.sv
// rtl/frequency_meter.sv - gated-window frequency meter; FREQ_METER_HOLD_EN adds a HOLD input that suppresses publishing
module frequency_meter
  import frequency_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned GATE_W      = DEF_GATE_W,
  parameter int unsigned COUNT_W     = DEF_COUNT_W
) (
  input  logic               CLK_50M,
  input  logic               RST_N,
  input  logic               SIG_IN,
`ifdef FREQ_METER_HOLD_EN
  input  logic               HOLD,
`endif
  output logic [COUNT_W-1:0] FREQ,
  output logic               FREQ_VALID,
  output logic               OVERFLOW
);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [ACC_W-1:0]  COUNT_MAX = (COUNT_W >= ACC_W) ? {ACC_W{1'b1}}
                                          : ((ACC_W'(1) << COUNT_W) - ACC_W'(1));

  logic edge_pulse;

  sync_edge_detect u_sig_edge (
    .clk        (CLK_50M),
    .rst_n      (RST_N),
    .async_in   (SIG_IN),
    .edge_pulse (edge_pulse)
  );

  meter_state_e       state_q, state_d;
  logic               settle_q, settle_d;
  logic [GATE_W-1:0]  gate_q, gate_d;
  // Bits above COUNT_W never leave zero because saturation stops at COUNT_MAX.
  logic [ACC_W-1:0]   count_q, count_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [COUNT_W-1:0] freq_q, freq_d;
  logic               freq_valid_q, freq_valid_d;
  logic               overflow_q, overflow_d;

  logic [ACC_W:0]     inc_res;
  logic               window_close;
  logic               publish;

  // Next-state: settle, run the gate, accumulate edges, publish at window close.
  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    gate_d       = gate_q;
    count_d      = count_q;
    ovf_acc_d    = ovf_acc_q;
    freq_d       = freq_q;
    freq_valid_d = 1'b0;
    overflow_d   = overflow_q;

    inc_res      = sat_inc(count_q, edge_pulse, COUNT_MAX);
    window_close = (state_q == ST_MEASURE) && (gate_q == GATE_LAST);
`ifdef FREQ_METER_HOLD_EN
    publish      = window_close && !HOLD;
`else
    publish      = window_close;
`endif

    case (state_q)
      ST_SETTLE: begin
        gate_d    = '0;
        count_d   = '0;
        ovf_acc_d = 1'b0;
        settle_d  = 1'b1;
        if (settle_q) begin
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (window_close) begin
          // An edge on the closing cycle still belongs to this window.
          gate_d    = '0;
          count_d   = '0;
          ovf_acc_d = 1'b0;
          if (publish) begin
            freq_d       = inc_res[COUNT_W-1:0];
            overflow_d   = ovf_acc_q | inc_res[ACC_W];
            freq_valid_d = 1'b1;
          end
        end else begin
          gate_d    = gate_q + GATE_W'(1);
          count_d   = inc_res[ACC_W-1:0];
          ovf_acc_d = ovf_acc_q | inc_res[ACC_W];
        end
      end
    endcase
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_SETTLE;
      settle_q     <= 1'b0;
      gate_q       <= '0;
      count_q      <= '0;
      ovf_acc_q    <= 1'b0;
      freq_q       <= '0;
      freq_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      gate_q       <= gate_d;
      count_q      <= count_d;
      ovf_acc_q    <= ovf_acc_d;
      freq_q       <= freq_d;
      freq_valid_q <= freq_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign FREQ       = freq_q;
  assign FREQ_VALID = freq_valid_q;
  assign OVERFLOW   = overflow_q;

endmodule

// File: tb/tb_frequency_meter.sv
// tb/tb_frequency_meter.sv - directed self-checking bench for frequency_meter
module tb_frequency_meter;

  logic        clk;
  logic        rst_n;
  logic        sig_in;
  logic        hold;
  logic [25:0] freq;
  logic        freq_valid;
  logic        overflow;
  logic [2:0]  freq_sat;
  logic        freq_valid_sat;
  logic        overflow_sat;

  int vectors;
  int miscompares;
  int cyc;
  int mode;
  logic level;
  int rise_at;
  int at;

  frequency_meter #(.GATE_CYCLES(100), .GATE_W(7), .COUNT_W(26)) dut (
    .CLK_50M    (clk),
    .RST_N      (rst_n),
    .SIG_IN     (sig_in),
`ifdef FREQ_METER_HOLD_EN
    .HOLD       (hold),
`endif
    .FREQ       (freq),
    .FREQ_VALID (freq_valid),
    .OVERFLOW   (overflow)
  );

  frequency_meter #(.GATE_CYCLES(100), .GATE_W(7), .COUNT_W(3)) dut_sat (
    .CLK_50M    (clk),
    .RST_N      (rst_n),
    .SIG_IN     (sig_in),
`ifdef FREQ_METER_HOLD_EN
    .HOLD       (hold),
`endif
    .FREQ       (freq_sat),
    .FREQ_VALID (freq_valid_sat),
    .OVERFLOW   (overflow_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; cyc counts edges since reset release, stimulus is updated 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    case (mode)
      1:       sig_in = ((cyc + 5) % 10) < 5;
      2:       sig_in = (cyc >= rise_at);
      default: sig_in = level;
    endcase
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic wait_valid(output int when);
    when = -1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (freq_valid === 1'b1) begin
        when = cyc;
        break;
      end
    end
  endtask

  task automatic apply_reset(input int new_mode, input logic new_level);
    rst_n  = 1'b0;
    mode   = new_mode;
    level  = new_level;
    sig_in = (new_mode == 0) ? new_level : 1'b0;
    #1;
    check("rst_freq", freq, 0);
    check("rst_valid", freq_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_freq_sat", freq_sat, 0);
    check("rst_ovf_sat", overflow_sat, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    mode        = 0;
    level       = 1'b0;
    rise_at     = 0;
    rst_n       = 1'b0;
    sig_in      = 1'b0;
    hold        = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Period-10 square wave: 10 edges per window, the 3-bit instance saturates.
    apply_reset(1, 1'b0);
    wait_valid(at);
    check("w1_at", at, 102);
    check("w1_freq", freq, 10);
    check("w1_ovf", overflow, 0);
    check("w1_valid_sat", freq_valid_sat, 1);
    check("w1_freq_sat", freq_sat, 7);
    check("w1_ovf_sat", overflow_sat, 1);
    step();
    check("w1_pulse_width", freq_valid, 0);
    check("w1_freq_held", freq, 10);
    wait_valid(at);
    check("w2_at", at, 202);
    check("w2_freq", freq, 10);
    check("w2_freq_sat", freq_sat, 7);
    check("w2_ovf_sat", overflow_sat, 1);
    mode  = 0;
    level = 1'b0;
    wait_valid(at);
    check("w3_at", at, 302);
    check("w3_freq", freq, 0);
    check("w3_ovf", overflow, 0);
    check("w3_freq_sat", freq_sat, 0);
    check("w3_ovf_sat", overflow_sat, 0);

    // Single edge landing on the closing cycle, then one cycle later.
    rise_at = 98;
    apply_reset(2, 1'b0);
    wait_valid(at);
    check("close_w1_at", at, 102);
    check("close_w1_freq", freq, 1);
    wait_valid(at);
    check("close_w2_freq", freq, 0);
    rise_at = 99;
    apply_reset(2, 1'b0);
    wait_valid(at);
    check("after_w1_freq", freq, 0);
    wait_valid(at);
    check("after_w2_freq", freq, 1);

    // Reset in the middle of window 2 after 7 edges; only post-reset edges count.
    apply_reset(1, 1'b0);
    wait_valid(at);
    check("mid_w1_freq", freq, 10);
    step_to(175);
    apply_reset(1, 1'b0);
    step_to(30);
    mode  = 0;
    level = 1'b0;
    wait_valid(at);
    check("mid_post_at", at, 102);
    check("mid_post_freq", freq, 3);
    check("mid_post_freq_sat", freq_sat, 3);
    check("mid_post_ovf_sat", overflow_sat, 0);

    // Input held high through reset release is not an edge.
    apply_reset(0, 1'b1);
    wait_valid(at);
    check("high_w1_freq", freq, 0);
    wait_valid(at);
    check("high_w2_freq", freq, 0);
    check("high_w2_at", at, 202);

`ifdef FREQ_METER_HOLD_EN
    // HOLD across the second close suppresses that publish only.
    apply_reset(1, 1'b0);
    wait_valid(at);
    check("hold_w1_freq", freq, 10);
    step_to(150);
    hold = 1'b1;
    step_to(202);
    check("hold_close_valid", freq_valid, 0);
    check("hold_close_freq", freq, 10);
    step_to(250);
    hold = 1'b0;
    wait_valid(at);
    check("hold_w3_at", at, 302);
    check("hold_w3_freq", freq, 10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
